sub_borrow_pipe: RTL and testbench
==================================

Name: sub_borrow_pipe

Overview:
- Pipelined WIDTH-bit subtractor computing a - b - borrow_in.
- Resolves the borrow chain one slice per stage, in the opposite arithmetic direction to the add-side carry levels of the VLIW integer ALU.
- Sits in the ALU SUB/CMP lane behind the issue stage.
- Uses a valid/ready handshake on both sides so the writeback arbiter can stall it.

Parameters:
- WIDTH, 64: operand and result width in bits.
- STAGES, 4: number of pipeline stages. WIDTH must divide evenly by STAGES. Each stage resolves WIDTH/STAGES result bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset; deassertion is synchronised externally.
- in_valid  in  1  operand beat present.
- in_ready  out  1  pipeline can accept a beat this cycle.
- in_a  in  WIDTH  minuend.
- in_b  in  WIDTH  subtrahend.
- in_borrow  in  1  borrow-in, for multi-word subtract.
- in_tag  in  6  destination register tag; passed through unchanged.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts the result this cycle.
- out_diff  out  WIDTH  result of a - b - borrow_in, mod 2^WIDTH.
- out_borrow  out  1  borrow out of the MSB (1 means a < b + borrow_in, unsigned).
- out_ovf  out  1  signed overflow.
- out_zero  out  1  out_diff == 0.
- out_tag  out  6  tag that belongs to out_diff.

Behaviour:
- Reset (async, rst_n=0):
  - All stage valid bits clear immediately.
  - out_valid=0, out_diff=0, out_borrow=0, out_ovf=0, out_zero=0, out_tag=0.
  - in_ready=1 once reset is released.
  - A reset in the middle of operation discards every in-flight beat; nothing is replayed.
- Slice width is S = WIDTH/STAGES.
- Stage k (k = 0..STAGES-1):
  - Computes diff[k*S +: S] and borrow_k from a, b and borrow_{k-1} held in its input register. borrow_{-1} = in_borrow.
  - Forwards to stage k+1: the unresolved upper operand bits, the diff bits already resolved, the borrow, and the tag.
  - Storage narrows stage by stage: each stage drops the operand bits it has consumed.
- The last stage register drives the out_* ports directly, so outputs are registered.
- Latency is exactly STAGES cycles from an accepted input (in_valid & in_ready) to out_valid, when there is no backpressure.
- Throughput is one beat per cycle.
- Stage advance:
  - ready_k = !valid_k | ready_{k+1}.
  - ready_STAGES = out_ready.
  - in_ready = ready_0.
  - A stage register loads when its own ready is high. Its valid then takes the upstream valid.
  - Bubbles collapse: an empty stage accepts data even while downstream is stalled.
- Stalls:
  - While out_valid=1 and out_ready=0, every out_* port holds stable.
  - A full pipeline under stall holds exactly STAGES beats, with in_ready=0.
- Simultaneous accept and emit on a full pipeline is allowed. No beat is lost or duplicated.
- Flags (computed in the final stage):
  - out_ovf = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]).
  - out_zero is computed from the full diff.
- Data is don't-care while the corresponding valid is 0. The bench must not check it.
- No internal state other than the pipeline registers. No counters survive beats.

Decomposition:
- Package alu_sub_pkg:
  - ALU_WIDTH=64, TAG_W=6.
  - Typedef sub_flags_t {borrow, ovf, zero}.
  - Function slice_sub(a_s, b_s, bin) returning {bout, diff_s}.
- One sub-module: sub_slice_stage.
  - A single parameterised stage register containing the slice subtract and the valid/ready logic.
  - Instantiated STAGES times with a generate loop.
  - The top level adds the final flag logic and the port mapping.

Test Plan:
- Basic: a=5, b=3, borrow=0, out_ready=1 → after 4 cycles: diff=2, borrow=0, ovf=0, zero=0, tag echoed.
- Wrap: a=0, b=1 → diff=0xFFFF_FFFF_FFFF_FFFF, borrow=1, ovf=0. Also a=b=0x1234, borrow=1 → diff=all ones, borrow=1.
- Signed overflow: a=0x8000_0000_0000_0000, b=1 → diff=0x7FFF_FFFF_FFFF_FFFF, ovf=1, borrow=0. Also a=b=0xDEAD → zero=1.
- Backpressure:
  - Stream 8 beats with out_ready=0 → in_ready drops after 4 accepted, outputs stay stable.
  - Release out_ready → all 8 results emerge in order with correct tags, none lost or duplicated.
- Throughput: 100 back-to-back random beats with out_ready=1 → 100 consecutive out_valid cycles starting in cycle 4; each result matches a reference model.
- Reset mid-flight: pull rst_n low with 3 beats in flight → out_valid=0 in the same cycle. After release, in_ready=1 and no stale result ever appears.

Source files
------------

// File: rtl/alu_sub_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_sub_pkg
// Brief    : Shared types, widths and slice-subtract helper for the SUB lane.
// Revision : 1.0 - initial release
// ============================================================================
package alu_sub_pkg;

    localparam int ALU_WIDTH = 64;
    localparam int TAG_W     = 6;

    typedef struct packed {
        logic borrow;
        logic ovf;
        logic zero;
    } sub_flags_t;

    // Slices arrive zero-extended, so bit ALU_WIDTH of the wide difference is the borrow-out.
    function automatic logic [ALU_WIDTH:0] slice_sub(
        input logic [ALU_WIDTH-1:0] a_s,
        input logic [ALU_WIDTH-1:0] b_s,
        input logic                 bin
    );
        logic [ALU_WIDTH:0] r;
        r = {1'b0, a_s} - {1'b0, b_s} - {{ALU_WIDTH{1'b0}}, bin};
        return r;
    endfunction

    // Payload entering stage idx: {tag, borrow, a-with-resolved-diff, unconsumed b}.
    function automatic int stage_in_w(input int width, input int stages, input int idx);
        return TAG_W + 1 + width + (width - idx * (width / stages));
    endfunction

    // The final stage drops b entirely and prepends {ovf, zero}.
    function automatic int stage_out_w(input int width, input int stages, input int idx);
        if (idx == stages - 1)
            return 2 + TAG_W + 1 + width;
        return stage_in_w(width, stages, idx + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sub_borrow_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : sub_borrow_pipe_if
// Brief    : Operand/result valid-ready bundle for the pipelined subtractor.
// Revision : 1.0 - initial release
// ============================================================================
interface sub_borrow_pipe_if
    import alu_sub_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_borrow;
    logic [TAG_W-1:0] in_tag;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_diff;
    logic             out_borrow;
    logic             out_ovf;
    logic             out_zero;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_a, in_b, in_borrow, in_tag, out_ready,
        input  in_ready, out_valid, out_diff, out_borrow, out_ovf, out_zero, out_tag
    );

    modport slave (
        input  in_valid, in_a, in_b, in_borrow, in_tag, out_ready,
        output in_ready, out_valid, out_diff, out_borrow, out_ovf, out_zero, out_tag
    );
endinterface
`default_nettype wire

// File: rtl/sub_slice_stage.sv
`default_nettype none
// ============================================================================
// Module   : sub_slice_stage
// Brief    : One pipeline stage: resolves one slice of a - b - borrow, holds it.
// Revision : 1.0 - initial release
// ============================================================================
module sub_slice_stage
    import alu_sub_pkg::*;
#(
    parameter int WIDTH  = ALU_WIDTH,
    parameter int STAGES = 4,
    parameter int IDX    = 0
)(
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      i_valid,
    output logic                                      o_ready,
    input  logic [stage_in_w(WIDTH, STAGES, IDX)-1:0]  i_pay,
    output logic                                      o_valid,
    input  logic                                      i_ready,
    output logic [stage_out_w(WIDTH, STAGES, IDX)-1:0] o_pay
);
    localparam int SW     = WIDTH / STAGES;
    localparam int BIN_W  = WIDTH - IDX * SW;
    localparam int PW_OUT = stage_out_w(WIDTH, STAGES, IDX);

    logic [TAG_W-1:0]  w_tag;
    logic              w_bin;
    logic [WIDTH-1:0]  w_a;
    logic [BIN_W-1:0]  w_b;
    logic [SW-1:0]     w_a_s;
    logic [SW-1:0]     w_b_s;
    logic [SW-1:0]     w_d_s;
    logic              w_bout;
    logic [WIDTH-1:0]  w_adiff;
    logic [PW_OUT-1:0] w_pay_next;

    logic              r_valid;
    logic [PW_OUT-1:0] r_pay;

    assign {w_tag, w_bin, w_a, w_b} = i_pay;

    // The lowest unconsumed b bits are always at the bottom of the narrowed b field.
    assign w_a_s  = w_a[IDX*SW +: SW];
    assign w_b_s  = w_b[SW-1:0];
    assign w_d_s  = SW'(slice_sub(ALU_WIDTH'(w_a_s), ALU_WIDTH'(w_b_s), w_bin));
    assign w_bout = 1'(slice_sub(ALU_WIDTH'(w_a_s), ALU_WIDTH'(w_b_s), w_bin) >> ALU_WIDTH);

    always_comb begin
        w_adiff                = w_a;
        w_adiff[IDX*SW +: SW]  = w_d_s;
    end

    if (IDX == STAGES - 1) begin : g_last
        logic w_ovf;
        logic w_zero;
        assign w_ovf      = (w_a[WIDTH-1] != w_b[BIN_W-1]) & (w_adiff[WIDTH-1] != w_a[WIDTH-1]);
        assign w_zero     = ~|w_adiff;
        assign w_pay_next = {w_ovf, w_zero, w_tag, w_bout, w_adiff};
    end else begin : g_mid
        assign w_pay_next = {w_tag, w_bout, w_adiff, w_b[BIN_W-1:SW]};
    end

    assign o_ready = !r_valid || i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_pay   <= '0;
        end else if (o_ready) begin
            r_valid <= i_valid;
            if (i_valid)
                r_pay <= w_pay_next;
        end
    end

    assign o_valid = r_valid;
    assign o_pay   = r_pay;

endmodule
`default_nettype wire

// File: rtl/sub_borrow_pipe.sv
`default_nettype none
// ============================================================================
// Module   : sub_borrow_pipe
// Brief    : STAGES-deep valid/ready pipelined subtractor, one slice per stage.
// Revision : 1.0 - initial release
// ============================================================================
module sub_borrow_pipe
    import alu_sub_pkg::*;
#(
    parameter int WIDTH  = ALU_WIDTH,
    parameter int STAGES = 4
)(
    input  logic              clk,
    input  logic              rst_n,
    sub_borrow_pipe_if.slave  bus
);
    localparam int LAST_W = stage_out_w(WIDTH, STAGES, STAGES - 1);

    logic [STAGES:0]   w_valid;
    logic [STAGES:0]   w_ready;
    logic [LAST_W-1:0] w_last;
    sub_flags_t        w_flags;

    assign w_valid[0]       = bus.in_valid;
    assign bus.in_ready     = w_ready[0];
    assign w_ready[STAGES]  = bus.out_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [stage_in_w(WIDTH, STAGES, k)-1:0]  w_pin;
        logic [stage_out_w(WIDTH, STAGES, k)-1:0] w_pout;

        if (k == 0) begin : g_first
            assign w_pin = {bus.in_tag, bus.in_borrow, bus.in_a, bus.in_b};
        end else begin : g_chain
            assign w_pin = g_stage[k-1].w_pout;
        end

        sub_slice_stage #(
            .WIDTH  (WIDTH),
            .STAGES (STAGES),
            .IDX    (k)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_valid (w_valid[k]),
            .o_ready (w_ready[k]),
            .i_pay   (w_pin),
            .o_valid (w_valid[k+1]),
            .i_ready (w_ready[k+1]),
            .o_pay   (w_pout)
        );
    end

    // The final stage register feeds the ports straight through.
    assign w_last = g_stage[STAGES-1].w_pout;
    assign {w_flags.ovf, w_flags.zero, bus.out_tag, w_flags.borrow, bus.out_diff} = w_last;

    assign bus.out_valid  = w_valid[STAGES];
    assign bus.out_borrow = w_flags.borrow;
    assign bus.out_ovf    = w_flags.ovf;
    assign bus.out_zero   = w_flags.zero;

endmodule
`default_nettype wire

// File: tb/tb_sub_borrow_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_sub_borrow_pipe
// Brief    : Self-checking bench: vector table, backpressure, throughput, reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sub_borrow_pipe;

    typedef struct packed {
        logic [63:0] diff;
        logic        borrow;
        logic        ovf;
        logic        zero;
        logic [5:0]  tag;
    } res_t;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        bin;
        logic [5:0]  tag;
        res_t        exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc_n = 0;
    int   n_emit = 0;
    int   first_emit = -1;
    int   last_emit = -1;
    logic hold_chk = 1'b0;
    res_t held;
    res_t sb_q[$];
    vec_t tbl[8];

    always #5 clk = ~clk;

    sub_borrow_pipe_if #(.WIDTH(64)) bus ();

    sub_borrow_pipe #(.WIDTH(64), .STAGES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference: unsigned compare for borrow, exact signed range test for overflow.
    function automatic res_t model(input logic [63:0] a, input logic [63:0] b,
                                   input logic bin, input logic [5:0] tag);
        res_t e;
        logic [65:0] s;
        e.diff   = a - b - 64'(bin);
        e.borrow = ({1'b0, a} < ({1'b0, b} + 65'(bin)));
        s        = {{2{a[63]}}, a} - {{2{b[63]}}, b} - 66'(bin);
        e.ovf    = !((s[65:63] == 3'b000) || (s[65:63] == 3'b111));
        e.zero   = (e.diff == 64'd0);
        e.tag    = tag;
        return e;
    endfunction

    function automatic res_t dut_out();
        res_t r;
        r.diff   = bus.out_diff;
        r.borrow = bus.out_borrow;
        r.ovf    = bus.out_ovf;
        r.zero   = bus.out_zero;
        r.tag    = bus.out_tag;
        return r;
    endfunction

    function automatic logic [63:0] rand64();
        case ($urandom_range(5))
            0:       return 64'd0;
            1:       return 64'h8000_0000_0000_0000;
            2:       return {32'd0, $urandom} << ($urandom_range(3) * 16);
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic chk_res(input string name, input res_t got, input res_t exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got diff=%h borrow=%0b ovf=%0b zero=%0b tag=%h, expected diff=%h borrow=%0b ovf=%0b zero=%0b tag=%h",
                     name, got.diff, got.borrow, got.ovf, got.zero, got.tag,
                     exp.diff, exp.borrow, exp.ovf, exp.zero, exp.tag);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic drive_beat(input logic v, input logic [63:0] a, input logic [63:0] b,
                              input logic bin, input logic [5:0] tag);
        bus.in_valid  = v;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_borrow = bin;
        bus.in_tag    = tag;
    endtask

    // Called at a negedge with inputs already driven; settles, scores, returns at the next negedge.
    task automatic cycle(output logic acc);
        res_t cur;
        #1;
        cyc_n++;
        acc = bus.in_valid && bus.in_ready;
        if (acc)
            sb_q.push_back(model(bus.in_a, bus.in_b, bus.in_borrow, bus.in_tag));
        cur = dut_out();
        if (bus.out_valid) begin
            if (hold_chk)
                chk_res("stall_hold", cur, held);
            if (bus.out_ready) begin
                if (sb_q.size() == 0) begin
                    chk_int("unexpected_result", 1, 0);
                end else begin
                    chk_res("scoreboard", cur, sb_q.pop_front());
                end
                n_emit++;
                if (first_emit < 0)
                    first_emit = cyc_n;
                last_emit = cyc_n;
            end
            hold_chk = !bus.out_ready;
            held     = cur;
        end else begin
            hold_chk = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic send_vec(input int i);
        int lat;
        @(negedge clk);
        drive_beat(1'b1, tbl[i].a, tbl[i].b, tbl[i].bin, tbl[i].tag);
        bus.out_ready = 1'b1;
        #1;
        chk_int($sformatf("vec%0d_in_ready", i), int'(bus.in_ready), 1);
        @(negedge clk);
        drive_beat(1'b0, $urandom, $urandom, 1'b0, 6'h3F);
        lat = 0;
        for (int c = 1; c <= 8; c++) begin
            #1;
            if (bus.out_valid) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
        chk_int($sformatf("vec%0d_latency", i), lat, 4);
        chk_res($sformatf("vec%0d_result", i), dut_out(), tbl[i].exp);
    endtask

    task automatic stream(input int n, input int vp, input int rp, input string name);
        int          sent = 0;
        int          guard = 0;
        logic        acc;
        logic [63:0] a, b;
        logic        bin;
        a = rand64(); b = ($urandom_range(3) == 0) ? a : rand64(); bin = 1'($urandom);
        while ((sent < n || sb_q.size() != 0) && guard < 20 * n + 100) begin
            drive_beat((sent < n) && ($urandom_range(99) < vp), a, b, bin, 6'(sent));
            bus.out_ready = ($urandom_range(99) < rp);
            cycle(acc);
            if (acc) begin
                sent++;
                a = rand64(); b = ($urandom_range(3) == 0) ? a : rand64(); bin = 1'($urandom);
            end
            guard++;
        end
        chk_int({name, "_undelivered"}, (n - sent) + sb_q.size(), 0);
    endtask

    initial begin
        logic        acc;
        int          idx;
        int          start_cyc;
        int          emit0;
        logic [63:0] ba[8];
        logic [63:0] bb[8];

        tbl[0] = '{64'd5, 64'd3, 1'b0, 6'h11, '{64'd2, 1'b0, 1'b0, 1'b0, 6'h11}};
        tbl[1] = '{64'd0, 64'd1, 1'b0, 6'h22, '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 6'h22}};
        tbl[2] = '{64'h1234, 64'h1234, 1'b1, 6'h33, '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 6'h33}};
        tbl[3] = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 6'h04, '{64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0, 6'h04}};
        tbl[4] = '{64'hDEAD, 64'hDEAD, 1'b0, 6'h3E, '{64'd0, 1'b0, 1'b0, 1'b1, 6'h3E}};
        tbl[5] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 6'h15,
                   '{64'h8000_0000_0000_0000, 1'b1, 1'b1, 1'b0, 6'h15}};
        tbl[6] = '{64'h0001_0000_0000_0000, 64'd0, 1'b1, 6'h2A, '{64'h0000_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 6'h2A}};
        tbl[7] = '{64'd0, 64'd0, 1'b1, 6'h01, '{64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 6'h01}};

        drive_beat(1'b0, 64'd0, 64'd0, 1'b0, 6'd0);
        bus.out_ready = 1'b0;

        // Power-on reset
        #1 rst_n = 1'b0;
        #1;
        chk_int("reset_out_valid", int'(bus.out_valid), 0);
        chk_res("reset_outputs", dut_out(), '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_int("reset_in_ready", int'(bus.in_ready), 1);

        // Directed vectors, one at a time
        for (int i = 0; i < 8; i++)
            send_vec(i);

        // Backpressure: eight beats offered into a stalled pipeline
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            ba[i] = rand64();
            bb[i] = rand64();
        end
        idx = 0;
        hold_chk = 1'b0;
        for (int c = 0; c < 12; c++) begin
            drive_beat(idx < 8, ba[idx % 8], bb[idx % 8], 1'(idx), 6'(6'h20 + idx));
            bus.out_ready = 1'b0;
            cycle(acc);
            if (acc) idx++;
        end
        chk_int("bp_accepted_under_stall", idx, 4);
        chk_int("bp_in_ready_full", int'(bus.in_ready), 0);
        chk_int("bp_out_valid_full", int'(bus.out_valid), 1);
        emit0 = n_emit;
        for (int g = 0; g < 100 && (idx < 8 || sb_q.size() != 0); g++) begin
            drive_beat(idx < 8, ba[idx % 8], bb[idx % 8], 1'(idx), 6'(6'h20 + idx));
            bus.out_ready = 1'b1;
            cycle(acc);
            if (acc) idx++;
        end
        chk_int("bp_emitted", n_emit - emit0, 8);
        chk_int("bp_pending", sb_q.size(), 0);

        // Throughput: 100 back-to-back beats, no backpressure
        first_emit = -1;
        start_cyc  = cyc_n;
        emit0      = n_emit;
        stream(100, 100, 100, "tput");
        chk_int("tput_first_out_cycle", first_emit - start_cyc - 1, 4);
        chk_int("tput_consecutive", last_emit - first_emit + 1, 100);
        chk_int("tput_count", n_emit - emit0, 100);

        // Random valid/ready traffic
        stream(300, 70, 60, "random");

        // Reset with beats in flight
        for (int i = 0; i < 3; i++) begin
            drive_beat(1'b1, rand64(), rand64(), 1'b0, 6'(i));
            bus.out_ready = 1'b0;
            cycle(acc);
        end
        drive_beat(1'b0, 64'd0, 64'd0, 1'b0, 6'd0);
        cycle(acc);
        chk_int("midrst_precond_out_valid", int'(bus.out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        chk_int("midrst_out_valid", int'(bus.out_valid), 0);
        chk_res("midrst_outputs", dut_out(), '0);
        sb_q.delete();
        hold_chk = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_int("midrst_in_ready", int'(bus.in_ready), 1);
        @(negedge clk);
        for (int c = 0; c < 10; c++) begin
            bus.out_ready = 1'b1;
            cycle(acc);
            chk_int("midrst_no_stale", int'(bus.out_valid), 0);
        end
        stream(100, 80, 80, "post_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
